serial_adder: RTL and testbench

//  Parametrised bit-serial N-bit adder. One full-adder cell (two half adders plus an OR) is reused over N cycles.

---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell reused over N cycles, valid/ready in and out.
// Optional subtract mode is built in when SERIAL_ADDER_SUB_EN is defined (adds the sub port).
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    aSh_q, aSh_d;
    logic [N-1:0]    bSh_q, bSh_d;
    logic [N-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [CW-1:0]   k_q, k_d;

    logic            accept;
    logic            lastBit;
    logic            bitSum;
    logic            bitCarry;

    assign accept  = i_valid && (state_q == IDLE);
    assign lastBit = (k_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (lastBit) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == IDLE);
        o_valid = (state_q == DONE);
        sum     = sum_q;
        cout    = cout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aSh_q   <= '0;
            bSh_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            aSh_q   <= aSh_d;
            bSh_q   <= bSh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            k_q     <= k_d;
        end
    end

    // The full-adder cell: two half adders plus an OR, fed from the LSBs of the shifters.
    always_comb begin
        bitSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
        bitCarry = (aSh_q[0] & bSh_q[0]) | (carry_q & (aSh_q[0] ^ bSh_q[0]));
    end

    always_comb begin
        aSh_d   = aSh_q;
        bSh_d   = bSh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    aSh_d = a;
`ifdef SERIAL_ADDER_SUB_EN
                    // Subtraction as a + ~b + 1; carry-out then means "no borrow".
                    bSh_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    bSh_d   = b;
                    carry_d = cin;
`endif
                    sum_d = '0;
                    k_d   = '0;
                end
            end
            RUN: begin
                aSh_d        = aSh_q >> 1;
                bSh_d        = bSh_q >> 1;
                sum_d        = sum_q >> 1;
                sum_d[N-1]   = bitSum;
                carry_d      = bitCarry;
                k_d          = k_q + 1'b1;
                if (lastBit) begin
                    cout_d = bitCarry;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an N=8 instance for the main cases and an
// N=1 instance for the full-adder truth table; subtract vectors build with SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    logic       clk;
    logic       rstN;

    logic       iValid;
    logic       oReady;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic       cinIn;
    logic       subIn;
    logic       oValid;
    logic       iReady;
    logic [7:0] sumOut;
    logic       coutOut;

    logic       iValid1;
    logic       oReady1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       sub1;
    logic       oValid1;
    logic       iReady1;
    logic [0:0] sum1;
    logic       cout1;

    int compareCount = 0;
    int failCount    = 0;
    int cycles;

    serial_adder #(.N(8)) dut8 (
        .clk     (clk),
        .rst_n   (rstN),
        .i_valid (iValid),
        .o_ready (oReady),
        .a       (aIn),
        .b       (bIn),
        .cin     (cinIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub     (subIn),
`endif
        .o_valid (oValid),
        .i_ready (iReady),
        .sum     (sumOut),
        .cout    (coutOut)
    );

    serial_adder #(.N(1)) dut1 (
        .clk     (clk),
        .rst_n   (rstN),
        .i_valid (iValid1),
        .o_ready (oReady1),
        .a       (a1),
        .b       (b1),
        .cin     (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub     (sub1),
`endif
        .o_valid (oValid1),
        .i_ready (iReady1),
        .sum     (sum1),
        .cout    (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operand pair on the N=8 instance and scramble the inputs after acceptance.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv, input logic sv);
        @(negedge clk);
        iValid = 1'b1;
        aIn    = av;
        bIn    = bv;
        cinIn  = cv;
        subIn  = sv;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        aIn    = ~av;
        bIn    = ~bv;
        cinIn  = ~cv;
        subIn  = ~sv;
    endtask

    task automatic waitResult(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!oValid && n < budget);
    endtask

    task automatic releaseResult(input string tag);
        @(negedge clk);
        iReady = 1'b1;
        @(posedge clk);
        #1;
        iReady = 1'b0;
        checkOutput({tag, "_validDrop"}, oValid, 1'b0);
        checkOutput({tag, "_readyBack"}, oReady, 1'b1);
    endtask

    task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic sv,
                         input logic [7:0] expSum, input logic expCout);
        int n;
        applyStimulus(av, bv, cv, sv);
        waitResult(40, n);
        checkOutput({tag, "_latency"}, n, 8);
        checkOutput({tag, "_valid"}, oValid, 1'b1);
        checkOutput({tag, "_sum"}, sumOut, expSum);
        checkOutput({tag, "_cout"}, coutOut, expCout);
    endtask

    initial begin
        rstN    = 1'b0;
        iValid  = 1'b0;
        aIn     = '0;
        bIn     = '0;
        cinIn   = 1'b0;
        subIn   = 1'b0;
        iReady  = 1'b0;
        iValid1 = 1'b0;
        a1      = '0;
        b1      = '0;
        cin1    = 1'b0;
        sub1    = 1'b0;
        iReady1 = 1'b0;

        $display("[TB] reset state");
        #12;
        checkOutput("rst_ready", oReady, 1'b1);
        checkOutput("rst_valid", oValid, 1'b0);
        checkOutput("rst_sum", sumOut, 8'h00);
        checkOutput("rst_cout", coutOut, 1'b0);
        @(negedge clk);
        rstN = 1'b1;

        $display("[TB] basic additions");
        runOp("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        releaseResult("zero");
        runOp("ffPlus1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        releaseResult("ffPlus1");
        runOp("a5Plus5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);

        $display("[TB] backpressure");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", oValid, 1'b1);
            checkOutput("bp_sum", sumOut, 8'h00);
            checkOutput("bp_cout", coutOut, 1'b1);
        end
        releaseResult("bp");
        runOp("mixed", 8'h3C, 8'h42, 1'b1, 1'b0, 8'h7F, 1'b0);
        releaseResult("mixed");

        $display("[TB] i_valid pulse during RUN");
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("pulse_readyLow", oReady, 1'b0);
        iValid = 1'b1;
        aIn    = 8'hFF;
        bIn    = 8'hFF;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        waitResult(40, cycles);
        checkOutput("pulse_valid", oValid, 1'b1);
        checkOutput("pulse_sum", sumOut, 8'h10);
        checkOutput("pulse_cout", coutOut, 1'b0);
        releaseResult("pulse");

        $display("[TB] reset mid-operation");
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midRst_valid", oValid, 1'b0);
        checkOutput("midRst_ready", oReady, 1'b1);
        checkOutput("midRst_sum", sumOut, 8'h00);
        checkOutput("midRst_cout", coutOut, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        runOp("afterRst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);
        releaseResult("afterRst");

`ifdef SERIAL_ADDER_SUB_EN
        $display("[TB] subtract mode");
        runOp("sub5m7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        releaseResult("sub5m7");
        runOp("sub7m5", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
        releaseResult("sub7m5");
`endif

        $display("[TB] N=1 truth table");
        for (int i = 0; i < 8; i++) begin
            logic [2:0] combo;
            logic [1:0] total;
            int         n;
            combo = 3'(i);
            total = 2'(combo[2]) + 2'(combo[1]) + 2'(combo[0]);
            @(negedge clk);
            iValid1 = 1'b1;
            a1      = combo[2];
            b1      = combo[1];
            cin1    = combo[0];
            @(posedge clk);
            #1;
            iValid1 = 1'b0;
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!oValid1 && n < 10);
            checkOutput("n1_latency", n, 1);
            checkOutput("n1_sum", sum1, total[0]);
            checkOutput("n1_cout", cout1, total[1]);
            @(negedge clk);
            iReady1 = 1'b1;
            @(posedge clk);
            #1;
            iReady1 = 1'b0;
            checkOutput("n1_release", oValid1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
